vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between two requesters: the pixel fetch unit and the CPU bus.
- The pixel fetch unit is paced by the VGA timing generator (active-video pixel reads) and has absolute priority. CPU reads and writes are served in the remaining cycles, which are mostly horizontal and vertical blanking.
- Sits between the timing/pixel pipeline, the CPU memory map and the VRAM macro.

Parameters:
- ADDR_W, 14, VRAM address width in bits.
- DATA_W, 8, VRAM data width in bits.

Ports:
- clk  in  1  system/pixel clock, rising-edge.
- nreset  in  1  asynchronous active-low reset.
- vid_req  in  1  pixel fetch wants a read in this cycle.
- vid_addr  in  ADDR_W  pixel fetch read address.
- vid_data  out  DATA_W  pixel read data.
- vid_valid  out  1  vid_data valid, one cycle per accepted vid_req.
- cpu_start  in  1  CPU access request; sampled only when cpu_busy=0.
- cpu_we  in  1  1 = write, 0 = read; latched with cpu_start.
- cpu_addr  in  ADDR_W  CPU address; latched with cpu_start.
- cpu_wdata  in  DATA_W  CPU write data; latched with cpu_start.
- cpu_rdata  out  DATA_W  CPU read data; held until the next CPU read completes.
- cpu_busy  out  1  CPU request accepted and not yet completed.
- cpu_done  out  1  one-cycle pulse when the CPU access completes.
- ram_addr  out  ADDR_W  VRAM address (registered).
- ram_we  out  1  VRAM write enable (registered).
- ram_d  out  DATA_W  VRAM write data (registered).
- ram_q  in  DATA_W  VRAM read data; valid the cycle after ram_addr is presented (1-cycle synchronous read).

Behaviour:
- Reset:
  - Asynchronous; all outputs 0 while nreset=0.
  - Any latched CPU request is dropped; no cpu_done is issued for it. Read pipeline tags are cleared.
- Slot arbitration, evaluated at every rising edge:
  - vid_req=1: video slot. ram_addr<=vid_addr, ram_we<=0. Video always wins; the CPU is stalled.
  - Else, CPU request pending and not yet issued: CPU slot. ram_addr<=cpu_addr_l, ram_we<=cpu_we_l, ram_d<=cpu_wdata_l.
  - Else: idle slot. ram_we<=0; ram_addr holds its last value.
  - ram_we is high for exactly one cycle per CPU write and never during a video slot.
- Read pipeline:
  - 2-stage tag shift register (VID, CPU_RD, NONE) follows each issued slot.
  - Stage 2 captures ram_q.
  - Video latency: vid_req sampled at edge k -> vid_valid=1 and vid_data valid after edge k+2. Fully pipelined, one result per cycle, back-to-back accepted.
- CPU state machine (IDLE, WAIT, RD_PEND):
  - IDLE: cpu_start=1 latches we/addr/wdata, sets cpu_busy=1 and moves to WAIT. Same edge: the request is not yet visible to the arbiter.
  - WAIT: on the first CPU slot issued:
    - Write: cpu_done pulses after the issuing edge + 1 (edge k+1), cpu_busy clears on that same edge, state goes to IDLE.
    - Read: go to RD_PEND.
  - RD_PEND: when the CPU_RD tag reaches stage 2 (edge k+2), cpu_rdata<=ram_q, cpu_done=1 for one cycle, cpu_busy=0, state goes to IDLE.
  - cpu_start while cpu_busy=1: ignored, no queueing.
  - cpu_start in the same cycle cpu_done is high: accepted, because cpu_busy is already 0.
- Minimum CPU latency, no video contention: start at edge s -> write done at edge s+2, read done at edge s+3.
- Contention: a CPU access waits while vid_req is held. Unbounded waiting is permitted by design; blanking guarantees service each line.
- Simultaneous vid_req and pending CPU: video issued; CPU retried next free cycle with its latched values unchanged.
- Address/data widths pass through unchanged; no arithmetic or wrap is performed by this block.

Test Plan:
- Reset: assert nreset=0 mid CPU read (state RD_PEND) -> all outputs 0 immediately. After release, no cpu_done; cpu_busy=0.
- Video streaming: vid_req=1 for 4 cycles, addr 0x0100..0x0103, RAM preloaded with addr[7:0] -> vid_valid high 4 consecutive cycles starting edge k+2, data 0x00,0x01,0x02,0x03; ram_we stays 0.
- Idle CPU write then read: write 0x5A to 0x1234, then read 0x1234 -> ram_we single-cycle pulse with ram_addr=0x1234, ram_d=0x5A; write done at s+2; read cpu_rdata=0x5A with cpu_done at s+3.
- Contention: CPU read of 0x0010 started while vid_req is held 10 cycles -> ram_addr shows only video addresses for 10 cycles. CPU issued in the first cycle vid_req=0; cpu_done 2 edges after issue; video results unaffected.
- Busy protection: second cpu_start with addr 0x0020 while cpu_busy=1 -> ignored; only 0x0010 accessed. A new cpu_start in the cpu_done cycle is accepted.
- Randomized interleave: 10k cycles of random vid_req/CPU traffic against a scoreboard model -> every vid_req yields exactly one vid_valid at +2 edges, every accepted CPU op yields exactly one cpu_done, and read data matches the model.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters and the VRAM macro.
// vid_req is always taken; vid_valid follows two cycles later. cpu_start is taken only while cpu_busy=0, and cpu_done pulses once per taken request.
interface vram_arbiter_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
);
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic [DATA_W-1:0] vid_data;
   logic              vid_valid;
   logic              cpu_start;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_busy;
   logic              cpu_done;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_d;
   logic [DATA_W-1:0] ram_q;

   modport master (
      output vid_req, vid_addr, cpu_start, cpu_we, cpu_addr, cpu_wdata, ram_q,
      input  vid_data, vid_valid, cpu_rdata, cpu_busy, cpu_done, ram_addr, ram_we, ram_d
   );

   modport slave (
      input  vid_req, vid_addr, cpu_start, cpu_we, cpu_addr, cpu_wdata, ram_q,
      output vid_data, vid_valid, cpu_rdata, cpu_busy, cpu_done, ram_addr, ram_we, ram_d
   );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: pixel fetch has absolute priority, CPU accesses fill
// the remaining slots. Reads return through a 2-stage tag pipeline.
module vram_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
) (
   input  logic          clk,
   input  logic          nreset,
   vram_arbiter_if.slave bus,
   output logic [1:0]    o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RD_PEND = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_VID  = 2'd1,
      TAG_CPU  = 2'd2
   } tag_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_busy;
   logic              w_busy_nxt;
   logic              r_done;
   logic              w_done_nxt;
   logic              r_wr_pend;
   logic              w_wr_pend_nxt;
   logic              w_latch;
   logic              w_issue;
   logic              w_rd_capture;

   logic              r_we_l;
   logic [ADDR_W-1:0] r_addr_l;
   logic [DATA_W-1:0] r_wdata_l;

   tag_t              r_tag1;
   tag_t              r_tag2;
   logic [ADDR_W-1:0] r_ram_addr;
   logic              r_ram_we;
   logic [DATA_W-1:0] r_ram_d;
   logic [DATA_W-1:0] r_vid_data;
   logic              r_vid_valid;
   logic [DATA_W-1:0] r_cpu_rdata;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state   <= ST_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_wr_pend <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_wr_pend <= w_wr_pend_nxt;
      end
   end

   // A write completes one edge after it is issued; r_wr_pend marks that cycle.
   always_comb begin
      w_state_nxt   = r_state;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_wr_pend_nxt = r_wr_pend;
      w_latch       = 1'b0;
      w_issue       = 1'b0;
      w_rd_capture  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.cpu_start) begin
               w_latch     = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_wr_pend) begin
               w_done_nxt    = 1'b1;
               w_busy_nxt    = 1'b0;
               w_wr_pend_nxt = 1'b0;
               w_state_nxt   = ST_IDLE;
            end else if (!bus.vid_req) begin
               w_issue = 1'b1;
               if (r_we_l) begin
                  w_wr_pend_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_RD_PEND;
               end
            end
         end
         ST_RD_PEND: begin
            if (r_tag2 == TAG_CPU) begin
               w_rd_capture = 1'b1;
               w_done_nxt   = 1'b1;
               w_busy_nxt   = 1'b0;
               w_state_nxt  = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_we_l    <= 1'b0;
         r_addr_l  <= '0;
         r_wdata_l <= '0;
      end else if (w_latch) begin
         r_we_l    <= bus.cpu_we;
         r_addr_l  <= bus.cpu_addr;
         r_wdata_l <= bus.cpu_wdata;
      end
   end

   // Slot selection: video beats CPU; an idle slot keeps the last address.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_ram_addr <= '0;
         r_ram_we   <= 1'b0;
         r_ram_d    <= '0;
         r_tag1     <= TAG_NONE;
         r_tag2     <= TAG_NONE;
      end else begin
         r_tag2 <= r_tag1;
         if (bus.vid_req) begin
            r_ram_addr <= bus.vid_addr;
            r_ram_we   <= 1'b0;
            r_tag1     <= TAG_VID;
         end else if (w_issue) begin
            r_ram_addr <= r_addr_l;
            r_ram_we   <= r_we_l;
            r_ram_d    <= r_wdata_l;
            r_tag1     <= r_we_l ? TAG_NONE : TAG_CPU;
         end else begin
            r_ram_we <= 1'b0;
            r_tag1   <= TAG_NONE;
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_vid_valid <= 1'b0;
         r_vid_data  <= '0;
         r_cpu_rdata <= '0;
      end else begin
         r_vid_valid <= (r_tag2 == TAG_VID);
         if (r_tag2 == TAG_VID) begin
            r_vid_data <= bus.ram_q;
         end
         if (w_rd_capture) begin
            r_cpu_rdata <= bus.ram_q;
         end
      end
   end

   assign bus.vid_data  = r_vid_data;
   assign bus.vid_valid = r_vid_valid;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.cpu_busy  = r_busy;
   assign bus.cpu_done  = r_done;
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_we    = r_ram_we;
   assign bus.ram_d     = r_ram_d;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: synchronous RAM model, expected-value queues for video
// and CPU results, directed scenarios followed by a long random interleave.
module tb_vram_arbiter;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              nreset;
   logic [1:0]        dbg_state;
   int                cyc = 0;
   int                checks = 0;
   int                errors = 0;

   logic [DATA_W-1:0] vid_exp_q[$];
   int                vid_cyc_q[$];
   logic [DATA_W:0]   cpu_exp_q[$];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] mem [DEPTH];
   bit                ram_init_done;

   vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .nreset      (nreset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // VRAM model: 1-cycle synchronous read, old data on read-during-write.
   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= i[DATA_W-1:0];
         ram_init_done <= 1'b1;
      end else if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_d;
      end
      bus.ram_q <= mem[bus.ram_addr];
   end

   task automatic scoreboard_monitor();
      logic [DATA_W-1:0] e;
      int                c;
      logic [DATA_W:0]   ce;
      forever begin
         @(negedge clk);
         if (bus.vid_valid === 1'b1) begin
            checks++;
            if (vid_exp_q.size() == 0) begin
               errors++;
               $display("FAIL vid_unexpected: vid_valid at cycle %0d, required none", cyc);
            end else begin
               e = vid_exp_q.pop_front();
               c = vid_cyc_q.pop_front();
               if (bus.vid_data !== e || cyc != c) begin
                  errors++;
                  $display("FAIL vid_data: got %02h at cycle %0d, required %02h at cycle %0d",
                           bus.vid_data, cyc, e, c);
               end
            end
         end
         if (bus.cpu_done === 1'b1) begin
            checks++;
            if (cpu_exp_q.size() == 0) begin
               errors++;
               $display("FAIL cpu_unexpected: cpu_done at cycle %0d, required none", cyc);
            end else begin
               ce = cpu_exp_q.pop_front();
               if (ce[DATA_W] && bus.cpu_rdata !== ce[DATA_W-1:0]) begin
                  errors++;
                  $display("FAIL cpu_rdata: got %02h, required %02h at cycle %0d",
                           bus.cpu_rdata, ce[DATA_W-1:0], cyc);
               end
            end
         end
      end
   endtask

   task automatic cpu_drive(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.cpu_start = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
   endtask

   task automatic cpu_expect(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (we) begin
         cpu_exp_q.push_back({1'b0, {DATA_W{1'b0}}});
         ref_mem[a] = d;
      end else begin
         cpu_exp_q.push_back({1'b1, ref_mem[a]});
      end
   endtask

   task automatic vid_drive(input logic [ADDR_W-1:0] a);
      bus.vid_req  = 1'b1;
      bus.vid_addr = a;
      vid_exp_q.push_back(ref_mem[a]);
      vid_cyc_q.push_back(cyc + 3);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.vid_data, bus.vid_valid, bus.cpu_rdata, bus.cpu_busy, bus.cpu_done,
           bus.ram_addr, bus.ram_we, bus.ram_d} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: outputs not all zero during reset");
      end
      nreset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.cpu_busy !== 1'b0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_release: busy=%0b state=%0d, required 0 and 0", bus.cpu_busy, dbg_state);
      end
   endtask

   task automatic test_video_stream();
      int t0 = cyc;
      int nvalid = 0;
      int we_seen = 0;
      for (int j = 0; j < 9; j++) begin
         if (bus.ram_we === 1'b1) we_seen++;
         if (bus.vid_valid === 1'b1) begin
            checks++;
            if (cyc - t0 != 3 + nvalid) begin
               errors++;
               $display("FAIL vid_stream_timing: valid at offset %0d, required %0d", cyc - t0, 3 + nvalid);
            end
            nvalid++;
         end
         if (j < 4) vid_drive(ADDR_W'(32'h0100 + j));
         else bus.vid_req = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (nvalid != 4) begin
         errors++;
         $display("FAIL vid_stream_count: got %0d valids, required 4", nvalid);
      end
      checks++;
      if (we_seen != 0) begin
         errors++;
         $display("FAIL vid_stream_we: ram_we high %0d cycles, required 0", we_seen);
      end
   endtask

   task automatic test_cpu_write_read();
      int t0;
      int done_at;
      int we_cnt;
      t0 = cyc; done_at = -1; we_cnt = 0;
      cpu_drive(1'b1, 14'h1234, 8'h5A);
      cpu_expect(1'b1, 14'h1234, 8'h5A);
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         bus.cpu_start = 1'b0;
         if (j == 1) begin
            checks++;
            if (bus.cpu_busy !== 1'b1) begin
               errors++;
               $display("FAIL wr_busy: got %0b, required 1", bus.cpu_busy);
            end
         end
         if (bus.ram_we === 1'b1) begin
            we_cnt++;
            checks++;
            if (bus.ram_addr !== 14'h1234 || bus.ram_d !== 8'h5A) begin
               errors++;
               $display("FAIL wr_bus: addr=%04h d=%02h, required 1234 and 5a", bus.ram_addr, bus.ram_d);
            end
         end
         if (bus.cpu_done === 1'b1 && done_at < 0) done_at = cyc - t0;
      end
      checks++;
      if (we_cnt != 1) begin
         errors++;
         $display("FAIL wr_we_pulse: ram_we high %0d cycles, required 1", we_cnt);
      end
      checks++;
      if (done_at != 3) begin
         errors++;
         $display("FAIL wr_latency: done at offset %0d, required 3", done_at);
      end

      t0 = cyc; done_at = -1; we_cnt = 0;
      cpu_drive(1'b0, 14'h1234, 8'h00);
      cpu_expect(1'b0, 14'h1234, 8'h00);
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         bus.cpu_start = 1'b0;
         if (bus.ram_we === 1'b1) we_cnt++;
         if (bus.cpu_done === 1'b1 && done_at < 0) begin
            done_at = cyc - t0;
            checks++;
            if (bus.cpu_rdata !== 8'h5A) begin
               errors++;
               $display("FAIL rd_data: got %02h, required 5a", bus.cpu_rdata);
            end
         end
      end
      checks++;
      if (done_at != 4 || we_cnt != 0) begin
         errors++;
         $display("FAIL rd_latency: done at offset %0d with %0d writes, required 4 and 0", done_at, we_cnt);
      end
   endtask

   task automatic test_contention_busy();
      int first_done = -1;
      int second_done = -1;
      int bad = 0;
      for (int j = 0; j < 22; j++) begin
         if (j >= 1 && j <= 10) begin
            checks++;
            if (bus.ram_addr !== ADDR_W'(32'h0200 + j - 1) || bus.ram_we !== 1'b0) begin
               errors++;
               $display("FAIL cont_vid_slot: addr=%04h we=%0b at step %0d, required %04h and 0",
                        bus.ram_addr, bus.ram_we, j, 32'h0200 + j - 1);
            end
         end
         if (j == 11) begin
            checks++;
            if (bus.ram_addr !== 14'h0010 || bus.ram_we !== 1'b0) begin
               errors++;
               $display("FAIL cont_cpu_slot: addr=%04h we=%0b, required 0010 and 0", bus.ram_addr, bus.ram_we);
            end
         end
         if (bus.ram_we === 1'b1 || bus.ram_addr === 14'h0020) bad++;
         if (bus.cpu_done === 1'b1) begin
            if (first_done < 0) first_done = j;
            else if (second_done < 0) second_done = j;
         end
         if (j < 10) vid_drive(ADDR_W'(32'h0200 + j));
         else bus.vid_req = 1'b0;
         bus.cpu_start = 1'b0;
         if (j == 0) begin
            cpu_drive(1'b0, 14'h0010, 8'h00);
            cpu_expect(1'b0, 14'h0010, 8'h00);
         end else if (j == 2) begin
            cpu_drive(1'b1, 14'h0020, 8'hEE);
         end else if (j == 13) begin
            cpu_drive(1'b0, 14'h0030, 8'h00);
            cpu_expect(1'b0, 14'h0030, 8'h00);
         end
         @(negedge clk);
      end
      bus.cpu_start = 1'b0;
      checks++;
      if (first_done != 13) begin
         errors++;
         $display("FAIL cont_done: first done at step %0d, required 13", first_done);
      end
      checks++;
      if (second_done != 17) begin
         errors++;
         $display("FAIL busy_back_to_back: second done at step %0d, required 17", second_done);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL busy_ignored: ignored request touched RAM %0d times, required 0", bad);
      end
      checks++;
      if (vid_exp_q.size() != 0 || cpu_exp_q.size() != 0) begin
         errors++;
         $display("FAIL cont_drain: %0d video and %0d cpu results missing, required 0 and 0",
                  vid_exp_q.size(), cpu_exp_q.size());
      end
   endtask

   task automatic test_reset_mid_read();
      int saw_done = 0;
      cpu_drive(1'b0, 14'h1234, 8'h00);
      @(negedge clk);
      bus.cpu_start = 1'b0;
      @(negedge clk);
      checks++;
      if (dbg_state !== 2'd2 || bus.cpu_busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_state: state=%0d busy=%0b, required 2 and 1", dbg_state, bus.cpu_busy);
      end
      nreset = 1'b0;
      #1;
      checks++;
      if ({bus.vid_data, bus.vid_valid, bus.cpu_rdata, bus.cpu_busy, bus.cpu_done,
           bus.ram_addr, bus.ram_we, bus.ram_d} !== '0) begin
         errors++;
         $display("FAIL rst_async: outputs not zero immediately after reset assertion");
      end
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         if (bus.cpu_done === 1'b1) saw_done++;
      end
      checks++;
      if (saw_done != 0 || bus.cpu_busy !== 1'b0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL rst_drop: done=%0d busy=%0b state=%0d, required 0, 0, 0",
                  saw_done, bus.cpu_busy, dbg_state);
      end
   endtask

   task automatic test_random();
      bit cpu_out = 1'b0;
      bit we;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      for (int c = 0; c < 10000; c++) begin
         if (bus.cpu_done === 1'b1) cpu_out = 1'b0;
         checks++;
         if (bus.cpu_busy !== cpu_out) begin
            errors++;
            $display("FAIL rand_busy: got %0b, required %0b at cycle %0d", bus.cpu_busy, cpu_out, cyc);
         end
         if ($urandom_range(0, 99) < 60) vid_drive(ADDR_W'($urandom_range(0, 32'h0FFF)));
         else bus.vid_req = 1'b0;
         bus.cpu_start = 1'b0;
         if (!cpu_out && $urandom_range(0, 99) < 40) begin
            we = 1'($urandom_range(0, 1));
            a  = ADDR_W'(32'h1000 + $urandom_range(0, 255));
            d  = DATA_W'($urandom_range(0, 255));
            cpu_drive(we, a, d);
            cpu_expect(we, a, d);
            cpu_out = 1'b1;
         end else if (cpu_out && $urandom_range(0, 99) < 10) begin
            cpu_drive(1'b1, ADDR_W'($urandom_range(0, 32'h3FFF)), DATA_W'($urandom_range(0, 255)));
         end
         @(negedge clk);
      end
      bus.vid_req   = 1'b0;
      bus.cpu_start = 1'b0;
      for (int j = 0; j < 30; j++) begin
         if (bus.cpu_done === 1'b1) cpu_out = 1'b0;
         if (!cpu_out && vid_exp_q.size() == 0 && cpu_exp_q.size() == 0) break;
         @(negedge clk);
      end
      checks++;
      if (cpu_out || vid_exp_q.size() != 0 || cpu_exp_q.size() != 0) begin
         errors++;
         $display("FAIL rand_drain: outstanding=%0b video left=%0d cpu left=%0d, required 0, 0, 0",
                  cpu_out, vid_exp_q.size(), cpu_exp_q.size());
      end
   endtask

   initial begin
      nreset        = 1'b0;
      bus.vid_req   = 1'b0;
      bus.vid_addr  = '0;
      bus.cpu_start = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = i[DATA_W-1:0];
      fork
         scoreboard_monitor();
      join_none
      test_reset();
      test_video_stream();
      test_cpu_write_read();
      test_contention_busy();
      test_reset_mid_read();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
